// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 target that oversamples sck/cs_n/pico, with a one-word TX holding register and a pulsed RX output.
// Define SPI_PERIPH_LSB_FIRST_EN to shift both TX and RX LSB first (default is MSB first).
module spi_peripheral #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = 8'hFF
) (
  input  logic                  clk_system_i,
  input  logic                  reset_n_i,
  input  logic                  sck_i,
  input  logic                  cs_n_i,
  input  logic                  pico_i,
  output logic                  poci_o,
  output logic                  poci_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  underrun_o,
  output logic                  busy_o
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sck_sync_reg, cs_n_sync_reg, pico_sync_reg;
  logic                   sck_q_reg, cs_n_q_reg;
  logic                   s_sck, s_cs_n, s_pico;
  logic                   sck_rise, sck_fall, cs_fall;

  logic [DATA_WIDTH-1:0]  tx_shift_reg, tx_shift_adv;
  logic [DATA_WIDTH-2:0]  rx_shift_reg;
  logic [DATA_WIDTH-1:0]  rx_shift_in;
  logic                   tx_bit;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [DATA_WIDTH-1:0]  hold_data_reg;
  logic                   hold_full_reg;
  logic [DATA_WIDTH-1:0]  rx_data_reg;
  logic                   rx_done_reg, rx_valid_reg, underrun_reg;

  logic load_tx, shift_tx, shift_rx, word_done, clr_cnt, poci_oe;

  always_ff @(posedge clk_system_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sck_sync_reg  <= '0;
      cs_n_sync_reg <= '1;
      pico_sync_reg <= '0;
      sck_q_reg     <= 1'b0;
      cs_n_q_reg    <= 1'b1;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], sck_i};
      cs_n_sync_reg <= {cs_n_sync_reg[SYNC_STAGES-2:0], cs_n_i};
      pico_sync_reg <= {pico_sync_reg[SYNC_STAGES-2:0], pico_i};
      sck_q_reg     <= s_sck;
      cs_n_q_reg    <= s_cs_n;
    end
  end

  assign s_sck  = sck_sync_reg[SYNC_STAGES-1];
  assign s_cs_n = cs_n_sync_reg[SYNC_STAGES-1];
  assign s_pico = pico_sync_reg[SYNC_STAGES-1];

  // sck edges only count while the target is selected
  assign sck_rise = ~s_cs_n & s_sck & ~sck_q_reg;
  assign sck_fall = ~s_cs_n & ~s_sck & sck_q_reg;
  assign cs_fall  = ~s_cs_n & cs_n_q_reg;

`ifdef SPI_PERIPH_LSB_FIRST_EN
  assign tx_bit       = tx_shift_reg[0];
  assign tx_shift_adv = {1'b0, tx_shift_reg[DATA_WIDTH-1:1]};
  assign rx_shift_in  = {s_pico, rx_shift_reg};
`else
  assign tx_bit       = tx_shift_reg[DATA_WIDTH-1];
  assign tx_shift_adv = {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
  assign rx_shift_in  = {rx_shift_reg, s_pico};
`endif

  always_ff @(posedge clk_system_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    shift_rx   = 1'b0;
    word_done  = 1'b0;
    clr_cnt    = 1'b0;
    poci_oe    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          load_tx    = 1'b1;
          clr_cnt    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        poci_oe = 1'b1;
        // deselect beats a coincident final rise: the edge is already masked
        if (s_cs_n) begin
          clr_cnt    = 1'b1;
          state_next = IDLE;
        end else if (sck_rise) begin
          shift_rx = 1'b1;
          if (bit_cnt_reg == LAST_BIT) begin
            word_done = 1'b1;
            load_tx   = 1'b1;
            clr_cnt   = 1'b1;
          end
        end else if (sck_fall && (bit_cnt_reg != '0)) begin
          shift_tx = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_system_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      bit_cnt_reg   <= '0;
      hold_data_reg <= '0;
      hold_full_reg <= 1'b0;
      rx_data_reg   <= '0;
      rx_done_reg   <= 1'b0;
      rx_valid_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;
      rx_done_reg  <= word_done;
      rx_valid_reg <= rx_done_reg;

      if (load_tx) begin
        if (hold_full_reg) begin
          tx_shift_reg <= hold_data_reg;
        end else begin
          tx_shift_reg <= IDLE_WORD;
          underrun_reg <= 1'b1;
        end
      end else if (shift_tx) begin
        tx_shift_reg <= tx_shift_adv;
      end

      // a load sees the pre-write state, so a same-cycle write refills for the next word
      if (load_tx && hold_full_reg) begin
        hold_full_reg <= 1'b0;
      end else if (tx_valid_i && !hold_full_reg) begin
        hold_full_reg <= 1'b1;
        hold_data_reg <= tx_data_i;
      end

      if (shift_rx) begin
`ifdef SPI_PERIPH_LSB_FIRST_EN
        rx_shift_reg <= rx_shift_in[DATA_WIDTH-1:1];
`else
        rx_shift_reg <= rx_shift_in[DATA_WIDTH-2:0];
`endif
      end
      if (word_done) begin
        rx_data_reg <= rx_shift_in;
      end

      if (clr_cnt) begin
        bit_cnt_reg <= '0;
      end else if (shift_rx) begin
        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign poci_o     = poci_oe ? tx_bit : 1'b1;
  assign poci_oe_o  = poci_oe;
  assign tx_ready_o = ~hold_full_reg;
  assign rx_data_o  = rx_data_reg;
  assign rx_valid_o = rx_valid_reg;
  assign underrun_o = underrun_reg;
  assign busy_o     = ~s_cs_n;

endmodule
